spi_reg_slave: RTL and testbench

Synthesizable SPI slave (responder) that implements the ADXL362-style register-access protocol on the far end of simple_spi_top. It decodes the command byte, then the address byte, then a data burst from SCLK/MOSI/nCS. It turns these into single-cycle register-bank read/write strobes and returns read data on MISO. It is oversampled on the system clock and is the synthesizable counterpart to the behavioural accelerometer model used in the SPI benches.

---
 rtl/spi_reg_slave.sv | 157 +++++++++++++++
 tb/tb_spi_reg_slave.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_slave.sv
// SPI mode-0 register-access responder (ADXL362-style command/address/burst),
// oversampled on clk_i and translated into single-cycle register strobes.
module spi_reg_slave #(
  parameter logic [7:0] CMD_WRITE = 8'h0A,
  parameter logic [7:0] CMD_READ  = 8'h0B
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       sclk_i,
  input  logic       mosi_i,
  input  logic       ncs_i,
  output logic       miso_o,
  output logic       miso_oe_o,
  output logic [7:0] reg_addr_o,
  output logic [7:0] reg_wdata_o,
  output logic       reg_we_o,
  output logic       reg_re_o,
  input  logic [7:0] reg_rdata_i,
  output logic       busy_o,
  output logic       cmd_err_o
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, RDATA, IGNORE} state_t;

  state_t     state, state_nxt;
  logic [1:0] sclk_sync, mosi_sync, ncs_sync;
  logic       sclk_d, ncs_d;
  logic       sclk_s, mosi_s, ncs_s;
  logic       sclk_rise, sclk_fall, ncs_fall, ncs_rise;
  logic [2:0] bit_cnt;
  logic [7:0] rx_shreg, rx_byte, tx_shreg, addr;
  logic       wr_mode, rdata_cap, byte_done;
  logic       do_err, do_write, do_read, latch_addr, set_wr, set_rd;

  assign sclk_s    = sclk_sync[1];
  assign mosi_s    = mosi_sync[1];
  assign ncs_s     = ncs_sync[1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign ncs_fall  = ~ncs_s & ncs_d;
  assign ncs_rise  = ncs_s & ~ncs_d;
  assign rx_byte   = {rx_shreg[6:0], mosi_s};
  assign byte_done = sclk_rise & ~ncs_s & (bit_cnt == 3'd7);

  // nCS synchronisers idle high so reset release never looks like a select edge
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sclk_sync <= 2'b00;
      mosi_sync <= 2'b00;
      ncs_sync  <= 2'b11;
      sclk_d    <= 1'b0;
      ncs_d     <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[0], sclk_i};
      mosi_sync <= {mosi_sync[0], mosi_i};
      ncs_sync  <= {ncs_sync[0], ncs_i};
      sclk_d    <= sclk_s;
      ncs_d     <= ncs_s;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    do_err     = 1'b0;
    do_write   = 1'b0;
    do_read    = 1'b0;
    latch_addr = 1'b0;
    set_wr     = 1'b0;
    set_rd     = 1'b0;
    if (ncs_rise) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (ncs_fall) state_nxt = CMD;
        CMD: begin
          if (byte_done) begin
            if (rx_byte == CMD_WRITE) begin
              state_nxt = ADDR;
              set_wr    = 1'b1;
            end else if (rx_byte == CMD_READ) begin
              state_nxt = ADDR;
              set_rd    = 1'b1;
            end else begin
              state_nxt = IGNORE;
              do_err    = 1'b1;
            end
          end
        end
        ADDR: begin
          if (byte_done) begin
            latch_addr = 1'b1;
            if (wr_mode) begin
              state_nxt = WDATA;
            end else begin
              state_nxt = RDATA;
              do_read   = 1'b1;
            end
          end
        end
        WDATA: if (byte_done) do_write = 1'b1;
        RDATA: if (byte_done) do_read = 1'b1;
        default: ;
      endcase
    end
  end

  // Receive shifter and bit counter; counter restarts on every select edge
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rx_shreg <= 8'h00;
      bit_cnt  <= 3'd0;
    end else begin
      if (sclk_rise && !ncs_s) rx_shreg <= rx_byte;
      if (ncs_fall || ncs_rise)       bit_cnt <= 3'd0;
      else if (sclk_rise && !ncs_s)   bit_cnt <= bit_cnt + 3'd1;
    end
  end

  // Address: loaded from the address byte, then advanced after each write
  // strobe or together with each read prefetch
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_mode     <= 1'b0;
      addr        <= 8'h00;
      reg_we_o    <= 1'b0;
      reg_re_o    <= 1'b0;
      reg_wdata_o <= 8'h00;
      cmd_err_o   <= 1'b0;
      rdata_cap   <= 1'b0;
      tx_shreg    <= 8'h00;
    end else begin
      if (set_wr)      wr_mode <= 1'b1;
      else if (set_rd) wr_mode <= 1'b0;
      if (latch_addr)                addr <= rx_byte;
      else if (do_read || reg_we_o)  addr <= addr + 8'd1;
      reg_we_o  <= do_write;
      reg_re_o  <= do_read;
      cmd_err_o <= do_err;
      if (do_write) reg_wdata_o <= rx_byte;
      rdata_cap <= reg_re_o;
      // The fall right after a completed byte leaves the reloaded MSB in place
      if (rdata_cap)                                tx_shreg <= reg_rdata_i;
      else if (sclk_fall && !ncs_s && bit_cnt != 0) tx_shreg <= {tx_shreg[6:0], 1'b0};
    end
  end

  assign reg_addr_o = addr;
  assign busy_o     = (state != IDLE);
  assign miso_oe_o  = (state == RDATA) && !ncs_s;
  assign miso_o     = miso_oe_o & tx_shreg[7];

endmodule

// File: tb/tb_spi_reg_slave.sv
// Bench for spi_reg_slave: acts as SPI master and as the register bank,
// checks strobes and MISO data against a transaction-level reference model.
`timescale 1ns/1ps
module tb_spi_reg_slave;

  logic       clk = 1'b0;
  logic       rst;
  logic       sclk, mosi, ncs;
  logic       miso, miso_oe;
  logic [7:0] reg_addr, reg_wdata;
  logic       reg_we, reg_re;
  logic [7:0] reg_rdata = 8'h00;
  logic       busy, cmd_err;

  spi_reg_slave dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .sclk_i      (sclk),
    .mosi_i      (mosi),
    .ncs_i       (ncs),
    .miso_o      (miso),
    .miso_oe_o   (miso_oe),
    .reg_addr_o  (reg_addr),
    .reg_wdata_o (reg_wdata),
    .reg_we_o    (reg_we),
    .reg_re_o    (reg_re),
    .reg_rdata_i (reg_rdata),
    .busy_o      (busy),
    .cmd_err_o   (cmd_err)
  );

  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  logic [15:0] we_q[$];
  logic [7:0] re_q[$];
  int         err_cnt, oe_seen, oe_bad, miso_bad, both_cnt;
  bit         oe_allowed = 1'b0;
  logic       busy_tr [8];
  int         half_ns = 60;
  bit         rd_pend = 1'b0;
  logic [7:0] rd_addr = 8'h00;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Register bank answers one clock after the read strobe with addr ^ 0xA5
  always @(negedge clk) begin
    if (rd_pend) reg_rdata = rd_addr ^ 8'hA5;
    rd_pend = reg_re;
    rd_addr = reg_addr;
    if (rst) begin
      if (reg_we) we_q.push_back({reg_addr, reg_wdata});
      if (reg_re) re_q.push_back(reg_addr);
      if (reg_we && reg_re) both_cnt++;
      if (cmd_err) err_cnt++;
      if (miso_oe) oe_seen++;
      if (miso_oe && !oe_allowed) oe_bad++;
      if (miso && !miso_oe) miso_bad++;
    end
  end

  task automatic clear_logs();
    we_q.delete();
    re_q.delete();
    err_cnt = 0; oe_seen = 0; oe_bad = 0; miso_bad = 0; both_cnt = 0;
  endtask

  task automatic load(input int n, input logic [7:0] b0, b1, b2, b3, b4);
    logic [7:0] b [5];
    b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3; b[4] = b4;
    tx_q.delete();
    for (int i = 0; i < n; i++) tx_q.push_back(b[i]);
  endtask

  task automatic xfer(input logic [7:0] tx, input int nbits, input bit allow, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mosi = tx[7-i];
      #(half_ns);
      sclk = 1'b1;
      rx[7-i] = miso;
      if (allow && i == 7) oe_allowed = 1'b1;
      #(half_ns);
      sclk = 1'b0;
    end
  endtask

  task automatic spi_run(input int partial);
    bit         is_rd;
    logic [7:0] r;
    @(posedge clk); #2;
    is_rd = (tx_q.size() > 1) && (tx_q[0] == 8'h0B);
    rx_q.delete();
    ncs = 1'b0;
    #(half_ns);
    for (int k = 0; k < tx_q.size(); k++) begin
      xfer(tx_q[k], 8, is_rd && k == 1, r);
      rx_q.push_back(r);
    end
    if (partial > 0) xfer(8'($urandom), partial, 1'b0, r);
    #(half_ns);
    ncs = 1'b1;
    for (int j = 0; j < 8; j++) begin
      @(posedge clk); #2;
      busy_tr[j] = busy;
    end
    oe_allowed = 1'b0;
  endtask

  // Reference: a write burst lands at consecutive (wrapping) addresses; a read
  // burst returns (addr+k)^A5 and strobes one address beyond the last byte
  task automatic check_txn(input string tag);
    logic [7:0] a;
    int         n;
    n = tx_q.size() - 2;
    a = tx_q[1];
    if (tx_q[0] == 8'h0A) begin
      check_val({tag, "_we_cnt"}, we_q.size(), n);
      check_val({tag, "_re_cnt"}, re_q.size(), 0);
      for (int k = 0; k < n && k < we_q.size(); k++) begin
        check_val($sformatf("%s_we%0d", tag, k), we_q[k], {a, tx_q[k+2]});
        a = a + 8'd1;
      end
    end else begin
      check_val({tag, "_re_cnt"}, re_q.size(), n + 1);
      check_val({tag, "_we_cnt"}, we_q.size(), 0);
      for (int k = 0; k <= n && k < re_q.size(); k++)
        check_val($sformatf("%s_re%0d", tag, k), re_q[k], 8'(tx_q[1] + 8'(k)));
      for (int k = 0; k < n; k++) begin
        check_val($sformatf("%s_miso%0d", tag, k), rx_q[k+2], a ^ 8'hA5);
        a = a + 8'd1;
      end
      check_val({tag, "_oe_seen"}, (oe_seen > 0), 1);
    end
    check_val({tag, "_oe_bad"}, oe_bad, 0);
    check_val({tag, "_miso_bad"}, miso_bad, 0);
    check_val({tag, "_both"}, both_cnt, 0);
  endtask

  initial begin
    logic [7:0] r;
    rst = 1'b0; sclk = 1'b0; mosi = 1'b0; ncs = 1'b1;
    clear_logs();
    repeat (3) @(posedge clk); #2;
    check_val("rst_miso", miso, 0);
    check_val("rst_oe", miso_oe, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_we", reg_we, 0);
    check_val("rst_re", reg_re, 0);
    check_val("rst_err", cmd_err, 0);
    check_val("rst_addr", reg_addr, 0);
    check_val("rst_wdata", reg_wdata, 0);
    rst = 1'b1;
    repeat (4) @(posedge clk);

    // Single write with busy deassert timing
    clear_logs(); load(3, 8'h0A, 8'h20, 8'h55, 8'h00, 8'h00); spi_run(0);
    check_txn("wr");
    check_val("wr_busy_hold", busy_tr[1], 1);
    check_val("wr_busy_idle", busy_tr[2], 0);

    // Burst read of three bytes from 0x00
    clear_logs(); load(5, 8'h0B, 8'h00, 8'h00, 8'h00, 8'h00); spi_run(0);
    check_txn("rd");
    if (rx_q.size() == 5) begin
      check_val("rd_b0", rx_q[2], 8'hA5);
      check_val("rd_b1", rx_q[3], 8'hA4);
      check_val("rd_b2", rx_q[4], 8'hA7);
    end else check_val("rd_rxlen", rx_q.size(), 5);

    // Address wrap
    clear_logs(); load(4, 8'h0A, 8'hFF, 8'h11, 8'h22, 8'h00); spi_run(0);
    check_txn("wrap");
    if (we_q.size() == 2) check_val("wrap_second", we_q[1], 16'h0022);

    // Unknown command, then recovery
    clear_logs(); load(3, 8'h0D, 8'h00, 8'h00, 8'h00, 8'h00); spi_run(0);
    check_val("bad_err", err_cnt, 1);
    check_val("bad_we", we_q.size(), 0);
    check_val("bad_re", re_q.size(), 0);
    check_val("bad_oe", oe_seen, 0);
    clear_logs(); load(3, 8'h0A, 8'h01, 8'h7E, 8'h00, 8'h00); spi_run(0);
    check_txn("recover");
    check_val("recover_err", err_cnt, 0);

    // Abort after five data bits
    clear_logs(); load(2, 8'h0A, 8'h10, 8'h00, 8'h00, 8'h00); spi_run(5);
    check_val("abort_we", we_q.size(), 0);
    check_val("abort_idle", busy_tr[7], 0);
    clear_logs(); load(3, 8'h0A, 8'h10, 8'h3C, 8'h00, 8'h00); spi_run(0);
    check_txn("after_abort");

    // Randomised bursts
    for (int t = 0; t < 8; t++) begin
      int n;
      clear_logs();
      half_ns = 10 * $urandom_range(5, 8);
      n = $urandom_range(1, 3);
      tx_q.delete();
      tx_q.push_back($urandom_range(0, 1) ? 8'h0B : 8'h0A);
      tx_q.push_back(8'($urandom));
      for (int k = 0; k < n; k++) tx_q.push_back(8'($urandom));
      spi_run(0);
      check_txn($sformatf("rnd%0d", t));
    end

    // Reset in the middle of the second read data byte
    half_ns = 60;
    clear_logs();
    @(posedge clk); #2;
    ncs = 1'b0;
    #(half_ns);
    xfer(8'h0B, 8, 1'b0, r);
    xfer(8'h00, 8, 1'b1, r);
    xfer(8'h00, 8, 1'b0, r);
    xfer(8'h00, 3, 1'b0, r);
    check_val("mid_busy_before", busy, 1);
    check_val("mid_oe_before", miso_oe, 1);
    rst = 1'b0;
    #1;
    check_val("mid_rst_miso", miso, 0);
    check_val("mid_rst_oe", miso_oe, 0);
    check_val("mid_rst_busy", busy, 0);
    check_val("mid_rst_we", reg_we, 0);
    check_val("mid_rst_re", reg_re, 0);
    ncs = 1'b1;
    oe_allowed = 1'b0;
    repeat (4) @(posedge clk); #2;
    rst = 1'b1;
    repeat (4) @(posedge clk);
    clear_logs(); load(3, 8'h0B, 8'h00, 8'h00, 8'h00, 8'h00); spi_run(0);
    check_txn("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
